fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 70 +++++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side streamer: output buffer state and depth.
package fifo_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  function automatic logic [1:0] occupancy(input fifo_state_e s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head drives the stream, tail absorbs a word that
// returns from the FIFO while the head is still waiting to be accepted.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output fifo_state_e      state,
  output logic [WIDTH-1:0] head
);

  fifo_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = push_data;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_d = TWO;
            tail_d  = push_data;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d = push_data;
          default: ;
        endcase
      end
      TWO: begin
        // Credit logic keeps push out of TWO; the push branch only guarantees no drop.
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign state = state_q;
  assign head  = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream adapter with credit-based rinc.
// Optional accepted-transfer counter output word_cnt under FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output fifo_state_e      dbg_state
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]      word_cnt
`endif
);

  // Stream handshake: a word transfers on every rising rclk edge where
  // m_valid and m_ready are both high; m_data holds while m_valid & ~m_ready.
  logic        inflight_q;
  logic        run_q;
  logic        pop;
  logic [2:0]  credit_need;
  logic [2:0]  credit_lim;
  fifo_state_e state;

  assign pop         = m_valid & m_ready;
  assign credit_need = {1'b0, occupancy(state)} + {2'b00, inflight_q};
  assign credit_lim  = 3'(BUF_DEPTH) + {2'b00, pop};
  // run_q holds off the first read until one edge after reset release.
  assign rinc        = run_q & ~rempty & (credit_need < credit_lim);

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      inflight_q <= rinc;
      run_q      <= 1'b1;
    end
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (rclk),
    .rst_n     (rrstn),
    .push      (inflight_q),
    .push_data (rdata),
    .pop       (pop),
    .state     (state),
    .head      (m_data)
  );

  assign m_valid   = (state != EMPTY);
  assign dbg_state = state;

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)   word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: FIFO model with registered read, word-index scoreboard, directed and random phases.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int W    = 8;
  localparam int MASK = 4095;

  logic          rclk = 1'b0;
  logic          rrstn;
  logic          rempty;
  logic          rinc;
  logic [W-1:0]  rdata = '0;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  fifo_state_e   dbg_state;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]   word_cnt;
`endif

  fifo_rd_stream #(.WIDTH(W)) dut (
    .rclk      (rclk),
    .rrstn     (rrstn),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .dbg_state (dbg_state)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  // Clock / reset
  always #5 rclk = ~rclk;

  // FIFO model: words written at wr_idx, read with one-cycle registered data.
  logic [W-1:0] mem [0:MASK];
  int wr_idx = 0;
  int rd_idx = 0;
  int exp_idx = 0;
  int acc_cnt = 0;
  int cyc = 0;

  assign rempty = (rd_idx == wr_idx);

  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (rinc) begin
      rdata  <= mem[rd_idx & MASK];
      rd_idx <= rd_idx + 1;
    end
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor
  int rinc_cnt, first_rinc, last_rinc;
  int valid_cnt, first_valid, last_valid;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge rclk) begin
    if (rrstn) begin
      if (rempty) check("no_rinc_when_empty", rinc, 0);
      check("outstanding_le_2", ((rd_idx - exp_idx) <= 2), 1);
      if (prev_stall) check("hold_data", m_data, prev_data);
      if (rinc) begin
        if (rinc_cnt == 0) first_rinc = cyc;
        last_rinc = cyc;
        rinc_cnt++;
      end
      if (m_valid) begin
        if (valid_cnt == 0) first_valid = cyc;
        last_valid = cyc;
        valid_cnt++;
      end
      if (m_valid && m_ready) begin
        check("stream_data", m_data, mem[exp_idx & MASK]);
        exp_idx++;
        acc_cnt++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] v);
    mem[wr_idx & MASK] = v;
    wr_idx++;
  endtask

  task automatic clear_stats();
    rinc_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic do_reset();
    rrstn = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_rinc", rinc, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", dbg_state, EMPTY);
    repeat (2) @(posedge rclk);
    exp_idx = rd_idx;
    acc_cnt = 0;
    @(negedge rclk);
    rrstn = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_idx != wr_idx && n < budget) begin
      tick();
      n++;
    end
    check(tag, (exp_idx == wr_idx), 1);
  endtask

  logic [W-1:0] first_word;
  int target;
  int n;

  initial begin
    rrstn   = 1'b0;
    m_ready = 1'b0;
    clear_stats();
    #3;
    check("init_m_valid", m_valid, 0);
    check("init_rinc", rinc, 0);
    check("init_m_data", m_data, 0);
    check("init_state", dbg_state, EMPTY);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrstn = 1'b1;
    tick();

    // Four words streamed with m_ready high
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(W'(8'h11 + i));
    wait_drain("drain_burst4", 30);
    check("burst_rinc_cnt", rinc_cnt, 4);
    check("burst_rinc_span", last_rinc - first_rinc, 3);
    check("burst_latency", first_valid - first_rinc, 2);
    check("burst_valid_cnt", valid_cnt, 4);
    check("burst_valid_span", last_valid - first_valid, 3);

    // Back-pressure: eight words, m_ready low
    tick();
    clear_stats();
    m_ready = 1'b0;
    first_word = W'($urandom_range(0, 255));
    push_word(first_word);
    for (int i = 1; i < 8; i++) push_word(W'($urandom_range(0, 255)));
    repeat (10) tick();
    check("bp_rinc_cnt", rinc_cnt, 2);
    check("bp_state", dbg_state, TWO);
    check("bp_head", m_data, first_word);
    m_ready = 1'b1;
    wait_drain("drain_bp", 40);
    check("bp_total_rinc", rinc_cnt, 8);

    // Single word: rempty rises as its data returns
    tick();
    clear_stats();
    push_word(8'hA5);
    wait_drain("drain_single", 20);
    check("single_rinc_cnt", rinc_cnt, 1);
    check("single_valid_cnt", valid_cnt, 1);

    // Random back-pressure and refill over 1000 words
    target = wr_idx + 1000;
    n = 0;
    while (exp_idx < target && n < 20000) begin
      if (wr_idx < target && (wr_idx - rd_idx) < 16 && $urandom_range(0, 9) < 7)
        push_word(W'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("rand_done", (exp_idx == target), 1);
    m_ready = 1'b1;
    wait_drain("drain_rand", 40);

    // Reset with one word buffered and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'($urandom));
    n = 0;
    while (!((rd_idx - exp_idx) == 2 && dbg_state == ONE) && n < 20) begin
      tick();
      n++;
    end
    check("rst_setup_reached", ((rd_idx - exp_idx) == 2 && dbg_state == ONE), 1);
    do_reset();
    m_ready = 1'b1;
    wait_drain("drain_after_rst", 40);

`ifdef FIFO_RD_STREAM_CNT_EN
    do_reset();
    check("cnt_after_rst", word_cnt, 0);
    m_ready = 1'b1;
    n = 0;
    while (acc_cnt < 65537 && n < 70000) begin
      if ((wr_idx - rd_idx) < 8) push_word(W'($urandom));
      tick();
      n++;
    end
    m_ready = 1'b0;
    @(negedge rclk);
    check("cnt_transfers", acc_cnt, 65537);
    check("cnt_wrap", word_cnt, 16'(acc_cnt));
    check("cnt_value_one", word_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
